// File: rtl/button_event_pkg.sv
// Shared definitions for the button event classifier: state encodings and
// default timing constants, also used by the LED effect controller.
package button_event_pkg;

  // Encodings are fixed so other blocks can decode the state if needed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Defaults for a 50 MHz system clock: 1 s long-press, 200 ms auto-repeat.
  localparam int unsigned DEF_LONG_CYCLES   = 50000000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10000000;
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/button_event.sv
// Classifies a debounced button level into one-cycle press, short, long and
// auto-repeat pulses, plus a held level. All outputs are registered.
module button_event
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pressed,
  input  logic enable,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  // Guarded so a disabled repeat does not underflow the constant.
  localparam logic [CNT_W-1:0] REP_LAST  =
      CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_prev;
  logic             r_press;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  state_e           w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic             w_rise;
  logic             w_press_d;
  logic             w_short_d;
  logic             w_long_d;
  logic             w_repeat_d;

  assign w_rise = pressed & ~r_prev;

  // Next-state, counter and pulse decode; release takes priority over thresholds.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_press_d  = 1'b0;
    w_short_d  = 1'b0;
    w_long_d   = 1'b0;
    w_repeat_d = 1'b0;
    if (!enable) begin
      w_state_d = ST_IDLE;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_d = ST_PRESS;
            w_cnt_d   = '0;
            w_press_d = 1'b1;
          end
        end
        ST_PRESS: begin
          if (!pressed) begin
            w_state_d = ST_IDLE;
            w_short_d = 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            w_state_d = ST_HOLD;
            w_cnt_d   = '0;
            w_long_d  = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (!pressed) begin
            w_state_d = ST_IDLE;
          end else if ((REPEAT_CYCLES != 0) && (r_cnt == REP_LAST)) begin
            w_cnt_d    = '0;
            w_repeat_d = 1'b1;
          end else if (r_cnt != '1) begin
            // Saturating so a disabled repeat never wraps the counter.
            w_cnt_d = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, edge history and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      // Preset high so a button held through reset is not seen as a new press.
      r_prev   <= 1'b1;
      r_press  <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_prev   <= pressed;
      r_press  <= w_press_d;
      r_short  <= w_short_d;
      r_long   <= w_long_d;
      r_repeat <= w_repeat_d;
      r_held   <= (w_state_d != ST_IDLE);
    end
  end

  assign press_pulse  = r_press;
  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign repeat_pulse = r_repeat;
  assign held         = r_held;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two instances (auto-repeat on / off) driven by the
// same inputs, compared every cycle against an age-based reference model.
module tb_button_event;

  logic clock;
  logic reset_n;
  logic pressed;
  logic enable;

  logic a_press, a_short, a_long, a_rep, a_held;
  logic b_press, b_short, b_long, b_rep, b_held;

  int total = 0;
  int bad   = 0;

  button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) u_dut_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .pressed      (pressed),
    .enable       (enable),
    .press_pulse  (a_press),
    .short_pulse  (a_short),
    .long_pulse   (a_long),
    .repeat_pulse (a_rep),
    .held         (a_held)
  );

  button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(0), .CNT_W(4)) u_dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .pressed      (pressed),
    .enable       (enable),
    .press_pulse  (b_press),
    .short_pulse  (b_short),
    .long_pulse   (b_long),
    .repeat_pulse (b_rep),
    .held         (b_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: age = edges since the press was accepted.
  int   m_long [2] = '{8, 8};
  int   m_rept [2] = '{4, 0};
  bit   m_prev [2];
  bit   m_act  [2];
  int   m_age  [2];
  logic e_press[2], e_short[2], e_long[2], e_rep[2], e_held[2];

  // Pulse tallies observed from the DUTs, cleared per scenario.
  int n_press[2], n_short[2], n_long[2], n_rep[2], n_held[2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 1'b1;
      m_act[k]  = 1'b0;
      m_age[k]  = 0;
      e_press[k] = 1'b0; e_short[k] = 1'b0; e_long[k] = 1'b0;
      e_rep[k]   = 1'b0; e_held[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic p, input logic en);
    for (int k = 0; k < 2; k++) begin
      e_press[k] = 1'b0; e_short[k] = 1'b0; e_long[k] = 1'b0; e_rep[k] = 1'b0;
      if (!en) begin
        m_act[k] = 1'b0;
      end else if (!m_act[k]) begin
        if (p && !m_prev[k]) begin
          m_act[k]   = 1'b1;
          m_age[k]   = 0;
          e_press[k] = 1'b1;
        end
      end else begin
        m_age[k]++;
        if (!p) begin
          m_act[k] = 1'b0;
          if (m_age[k] <= m_long[k]) e_short[k] = 1'b1;
        end else if (m_age[k] == m_long[k]) begin
          e_long[k] = 1'b1;
        end else if (m_age[k] > m_long[k] && m_rept[k] != 0 &&
                     ((m_age[k] - m_long[k]) % m_rept[k]) == 0) begin
          e_rep[k] = 1'b1;
        end
      end
      m_prev[k] = p;
      e_held[k] = m_act[k];
    end
  endtask

  task automatic check_all();
    chk("A.press", a_press, e_press[0]);
    chk("A.short", a_short, e_short[0]);
    chk("A.long",  a_long,  e_long[0]);
    chk("A.rep",   a_rep,   e_rep[0]);
    chk("A.held",  a_held,  e_held[0]);
    chk("A.onehot", ($countones({a_press, a_short, a_long, a_rep}) <= 1), 1'b1);
    chk("B.press", b_press, e_press[1]);
    chk("B.short", b_short, e_short[1]);
    chk("B.long",  b_long,  e_long[1]);
    chk("B.rep",   b_rep,   e_rep[1]);
    chk("B.held",  b_held,  e_held[1]);
    chk("B.onehot", ($countones({b_press, b_short, b_long, b_rep}) <= 1), 1'b1);
    n_press[0] += int'(a_press); n_short[0] += int'(a_short); n_long[0] += int'(a_long);
    n_rep[0]   += int'(a_rep);   n_held[0]  += int'(a_held);
    n_press[1] += int'(b_press); n_short[1] += int'(b_short); n_long[1] += int'(b_long);
    n_rep[1]   += int'(b_rep);   n_held[1]  += int'(b_held);
  endtask

  task automatic clear_tally();
    for (int k = 0; k < 2; k++) begin
      n_press[k] = 0; n_short[k] = 0; n_long[k] = 0; n_rep[k] = 0; n_held[k] = 0;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input logic p, input logic en);
    pressed = p;
    enable  = en;
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step(p, en);
    @(negedge clock);
    check_all();
  endtask

  task automatic run(input logic p, input logic en, input int n);
    for (int i = 0; i < n; i++) cycle(p, en);
  endtask

  initial begin
    logic rp;
    logic ren;
    int   len;

    reset_n = 1'b0;
    pressed = 1'b0;
    enable  = 1'b1;
    model_reset();
    clear_tally();
    repeat (2) @(negedge clock);
    check_all();
    reset_n = 1'b1;

    // 1: short press of 3 cycles.
    clear_tally();
    run(1'b0, 1'b1, 2);
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 3);
    chk_int("t1.press_cnt", n_press[0], 1);
    chk_int("t1.short_cnt", n_short[0], 1);
    chk_int("t1.long_cnt",  n_long[0],  0);
    chk_int("t1.held_cnt",  n_held[0],  3);

    // 2: long hold through three repeat points.
    clear_tally();
    run(1'b1, 1'b1, 21);
    run(1'b0, 1'b1, 3);
    chk_int("t2.long_cnt",  n_long[0],  1);
    chk_int("t2.rep_cnt",   n_rep[0],   3);
    chk_int("t2.short_cnt", n_short[0], 0);
    chk_int("t2.B.rep_cnt", n_rep[1],   0);

    // 3: release on the threshold edge.
    clear_tally();
    run(1'b1, 1'b1, 8);
    run(1'b0, 1'b1, 3);
    chk_int("t3.short_cnt", n_short[0], 1);
    chk_int("t3.long_cnt",  n_long[0],  0);

    // 4: button held through reset release.
    clear_tally();
    reset_n = 1'b0;
    run(1'b1, 1'b1, 2);
    reset_n = 1'b1;
    run(1'b1, 1'b1, 4);
    chk_int("t4.no_press", n_press[0], 0);
    run(1'b0, 1'b1, 1);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 2);
    chk_int("t4.press_cnt", n_press[0], 1);

    // 5: enable dropped mid-press, restored while still pressed.
    clear_tally();
    run(1'b1, 1'b1, 3);
    run(1'b1, 1'b0, 3);
    run(1'b1, 1'b1, 12);
    chk_int("t5.press_cnt", n_press[0], 1);
    chk_int("t5.long_cnt",  n_long[0],  0);
    chk_int("t5.short_cnt", n_short[0], 0);
    run(1'b0, 1'b1, 1);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 2);
    chk_int("t5.repress", n_press[0], 2);

    // 6: repeat disabled on B, reset asserted mid-hold.
    clear_tally();
    run(1'b1, 1'b1, 30);
    chk_int("t6.B.press_cnt", n_press[1], 1);
    chk_int("t6.B.long_cnt",  n_long[1],  1);
    chk_int("t6.B.rep_cnt",   n_rep[1],   0);
    chk("t6.B.held_pre", b_held, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6.B.held_async", b_held, 1'b0);
    chk("t6.A.held_async", a_held, 1'b0);
    model_reset();
    @(negedge clock);
    run(1'b1, 1'b1, 1);
    reset_n = 1'b1;
    clear_tally();
    run(1'b1, 1'b1, 4);
    run(1'b0, 1'b1, 2);
    chk_int("t6.post_reset_press", n_press[1], 0);

    // Randomized phase.
    rp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      len = $urandom_range(1, 30);
      rp  = ~rp;
      ren = ($urandom_range(0, 15) != 0);
      run(rp, ren, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
